// File: rtl/ftdi_pkg.sv
// Shared FSM encoding, default sizing and the packed output word layout
// for the FTDI synchronous-FIFO receive path.
package ftdi_pkg;

    localparam int FLUSH_CYCLES_DEF = 64;
    localparam int CNT_W_DEF        = 16;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_OE_SETUP   = 2'd1;
    localparam logic [1:0] ST_READ       = 2'd2;
    localparam logic [1:0] ST_TURNAROUND = 2'd3;

    // odd marks a word whose upper byte is flush padding
    typedef struct packed {
        logic       odd;
        logic [7:0] hi;
        logic [7:0] lo;
    } rx_word_t;

endpackage

// File: rtl/ftdi_rx_if.sv
// FTDI pin bundle plus the downstream FIFO write port of the receive path.
interface ftdi_rx_if;

    logic        rxf;
    logic [7:0]  d;
    logic        oe;
    logic        rd;
    logic        fifo_afull;
    logic        wrreq;
    logic [15:0] q;
    logic        q_odd;

    modport master (
        input  rxf, d, fifo_afull,
        output oe, rd, wrreq, q, q_odd
    );

    modport slave (
        output rxf, d, fifo_afull,
        input  oe, rd, wrreq, q, q_odd
    );

endinterface

// File: rtl/ftdi_rx_packer.sv
// Pairs accepted bytes into 16-bit words and flushes a lone byte after an
// idle timeout; also keeps the running byte count.
module ftdi_rx_packer
    import ftdi_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             accept,
    input  logic [7:0]       din,
    output logic             wrreq,
    output rx_word_t         word,
    output logic [CNT_W-1:0] byte_cnt
);

    localparam int             TW     = $clog2(FLUSH_CYCLES + 1);
    localparam logic [TW-1:0]  T_LAST = TW'(FLUSH_CYCLES - 1);

    logic [7:0]    low;
    logic          pending;
    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wrreq    <= 1'b0;
            word     <= '0;
            byte_cnt <= '0;
            low      <= 8'h00;
            pending  <= 1'b0;
            timer    <= '0;
        end else begin
            wrreq <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
                timer    <= '0;
                if (pending) begin
                    word    <= '{odd: 1'b0, hi: din, lo: low};
                    wrreq   <= 1'b1;
                    pending <= 1'b0;
                end else begin
                    low     <= din;
                    pending <= 1'b1;
                end
            // a pair write always takes priority over the timeout
            end else if (pending && timer == T_LAST) begin
                word    <= '{odd: 1'b1, hi: 8'h00, lo: low};
                wrreq   <= 1'b1;
                pending <= 1'b0;
                timer   <= '0;
            end else if (pending) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftdi_rx_controller.sv
// FTDI 245 synchronous-FIFO read controller: drives OE#/RD#, accepts bytes
// and hands them to the packer for 16-bit FIFO writes.
module ftdi_rx_controller
    import ftdi_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    ftdi_rx_if.master        bus,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             busy
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       accept;
    rx_word_t   word;

    // the FTDI hands over a byte on every edge with RD# low and data available
    assign accept = !bus.rd && !bus.rxf;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (!bus.rxf && !bus.fifo_afull) state_nxt = ST_OE_SETUP;
            ST_OE_SETUP: state_nxt = ST_READ;
            ST_READ:     if (bus.rxf || bus.fifo_afull) state_nxt = ST_TURNAROUND;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // pins follow the next state so they stay registered yet change on the transition edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            bus.oe <= 1'b1;
            bus.rd <= 1'b1;
        end else begin
            state  <= state_nxt;
            busy   <= (state_nxt != ST_IDLE);
            bus.oe <= !((state_nxt == ST_OE_SETUP) || (state_nxt == ST_READ));
            bus.rd <= (state_nxt != ST_READ);
        end
    end

    ftdi_rx_packer #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W       (CNT_W)
    ) u_packer (
        .clk     (clk),
        .n_rst   (n_rst),
        .accept  (accept),
        .din     (bus.d),
        .wrreq   (bus.wrreq),
        .word    (word),
        .byte_cnt(byte_cnt)
    );

    assign bus.q     = {word.hi, word.lo};
    assign bus.q_odd = word.odd;

endmodule

// File: doc/ftdi_rx_controller.md
FTDI_RX_CONTROLLER -- requirements
Module: ftdi_rx_controller

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 64, meaning idle cycles after which a lone pending byte is flushed.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the byte counter width.
REQ-003 SHALL have port clk  input  1  FTDI FCLK_OUT, 60 MHz, rising-edge; the single clock of the block.
REQ-004 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rxf  input  1  FTDI RXF#, low = host data available.
REQ-006 SHALL have port d  input  8  FTDI data bus, input direction.
REQ-007 SHALL have port oe  output  1  FTDI OE#, low = FTDI drives the bus.
REQ-008 SHALL have port rd  output  1  FTDI RD#, low = read strobe.
REQ-009 SHALL have port fifo_afull  input  1  downstream FIFO almost-full, high = stop reading.
REQ-010 SHALL have port wrreq  output  1  one-cycle write strobe for q.
REQ-011 SHALL have port q  output  16  packed word; first byte in [7:0], second byte in [15:8].
REQ-012 SHALL have port q_odd  output  1  high with wrreq when q[15:8] is flush padding.
REQ-013 SHALL have port byte_cnt  output  CNT_W  total bytes accepted; wraps to 0.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, OE_SETUP, READ and TURNAROUND.
REQ-016 SHALL, in IDLE with rxf=0 and fifo_afull=0, drive oe<=0 and go to OE_SETUP; otherwise it SHALL stay in IDLE.
REQ-017 SHALL, in OE_SETUP, drive rd<=0 and go to READ, so that oe leads rd by exactly 1 cycle.
REQ-018 SHALL accept a byte on every rising edge where the registered rd=0 and the sampled rxf=0, capturing d on that edge.
REQ-019 SHALL, in READ, on sampled rxf=1 or fifo_afull=1, drive rd<=1 and oe<=1 and go to TURNAROUND.
REQ-020 SHALL, when rxf=0 and fifo_afull=1 in the same READ cycle, still accept that byte and then exit.
REQ-021 SHALL spend exactly 1 cycle in TURNAROUND before returning to IDLE, with no re-entry in the same cycle.
REQ-022 SHALL pack bytes as follows: the 1st byte of a pair is held in a low register with pending=1; on the 2nd byte, q={byte2, low} and wrreq=1 on the next cycle, with q_odd=0 and pending=0.
REQ-023 SHALL give a latency of 1 clk from the edge accepting the 2nd byte to wrreq high.
REQ-024 SHALL keep wrreq high for exactly one cycle per word; q SHALL hold its value until the next wrreq.
REQ-025 SHALL preserve pairing across bursts: a pending byte stays paired with the first byte of the next burst.
REQ-026 SHALL flush: when pending=1 and no byte is accepted for FLUSH_CYCLES consecutive cycles, emit q={8'h00, low}, q_odd=1, wrreq=1, and clear pending.
REQ-027 SHALL reset the flush timer on every accepted byte.
REQ-028 SHALL never issue a flush and a pair write in the same cycle; the pair write wins and the timer is cleared.
REQ-029 SHALL increment byte_cnt by 1 per accepted byte, modulo 2^CNT_W, with no saturation.
REQ-030 SHALL produce at most 2 words after fifo_afull rises; the downstream almost-full threshold is sized for this.
REQ-031 SHALL, when rxf rises mid-burst, accept no byte on that edge, then raise rd and oe on the next edge.

Reset
REQ-032 SHALL, while n_rst=0, asynchronously force oe=1, rd=1, wrreq=0, q=16'h0000, q_odd=0, byte_cnt=0, busy=0, pending=0, flush timer=0, state=IDLE.
REQ-033 SHALL, on reset mid-burst, release rd and oe immediately and discard any pending byte.
REQ-034 SHALL restart cleanly from IDLE after reset release, with no spurious wrreq.

Structure
REQ-035 SHALL place the FSM state encoding and the default values of FLUSH_CYCLES and CNT_W in the shared package ftdi_pkg.
REQ-036 SHALL split packing and flush logic into the sub-module ftdi_rx_packer; the FSM and FTDI pins stay in ftdi_rx_controller.
REQ-037 SHALL register all outputs, with no combinational path from any input to oe, rd or wrreq.

Verification
REQ-038 SHALL cover: rxf=0 for 4 bytes 11,22,33,44, afull=0 -> oe falls at T, rd at T+1; words 16'h2211 and 16'h4433; byte_cnt=4.
REQ-039 SHALL cover: 3-byte burst AA,BB,CC, then rxf=1 for FLUSH_CYCLES -> word 16'hBBAA, then after 64 idle cycles 16'h00CC with q_odd=1.
REQ-040 SHALL cover: 1-byte burst 5A, gap of 10 cycles, then a burst with A5 -> single word 16'hA55A, q_odd=0, no flush.
REQ-041 SHALL cover: fifo_afull rising mid-burst together with rxf=0 -> that byte is accepted, rd/oe high next edge, ≤2 wrreq after afull, one TURNAROUND cycle.
REQ-042 SHALL cover: n_rst pulsed low with rd=0 and pending=1 -> rd=oe=1 immediately, byte_cnt=0, no wrreq after release until 2 new bytes arrive.
REQ-043 SHALL cover: CNT_W=4 with 17 bytes -> byte_cnt wraps to 1; packing unaffected.
